// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared constants and the program-loader state encoding for
//                the Y86-64 instruction-memory path.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Instruction memory geometry
    localparam int IMEM_BYTES  = 1024;
    localparam int IMEM_ADDR_W = 10;

    // Width of the little-endian length field in the loader frame header
    localparam int LEN_W = 16;

    // Loader state encoding; CHK is only reachable in checksum builds
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } loader_state_t;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Framed byte-stream loader for the Y86-64 instruction memory.
//                Frame = length[7:0], length[15:8], payload bytes, and an
//                optional trailing XOR checksum. Each payload byte becomes one
//                registered byte write starting at address 0. cpu_hold is low
//                only after a clean load (DONE).
//  Config      : define IMEM_LOADER_CHECKSUM_EN to expect and verify the
//                trailing XOR checksum byte (adds the CHK state).
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int ADDR_W    = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count,
    output logic              cpu_hold
);

    localparam logic [ADDR_W-1:0] C_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [LEN_W-1:0]  C_MAX_LEN   = LEN_W'(MEM_BYTES);

    loader_state_t     r_state;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_acc;
`endif

    logic              w_accept;
    logic [LEN_W-1:0]  w_len_full;
    logic [ADDR_W:0]   w_count_next;
    logic              w_last;

    // Handshake and header/payload bookkeeping helpers
    always_comb begin
        w_accept     = in_valid && r_in_ready;
        w_len_full   = {in_data, r_len[7:0]};
        w_count_next = r_count + C_COUNT_ONE;
        w_last       = (LEN_W'(w_count_next) == r_len);
    end

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_acc      <= '0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse per accepted payload byte
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    // in_valid is not consumed here; only start matters
                    if (start) begin
                        r_state    <= S_LEN_LO;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_count    <= '0;
                        r_addr     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_acc      <= '0;
`endif
                    end
                end

                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        r_state    <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[LEN_W-1:8] <= in_data;
                        if (w_len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
`endif
                        end else if (w_len_full > C_MAX_LEN) begin
                            // Oversize frame rejected before any write
                            r_state    <= S_ERROR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state    <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= in_data;
                        r_addr    <= r_addr + C_ADDR_ONE;
                        r_count   <= w_count_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_acc     <= r_acc ^ in_data;
`endif
                        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            // Final write and DONE entry share this edge
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
`endif
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (in_data == r_acc) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            // Already-written bytes are intentionally left in memory
                            r_state    <= S_ERROR;
                            r_error    <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign byte_count = r_count;
    assign cpu_hold   = r_cpu_hold;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader. Inputs change
//                on the falling edge; outputs are compared on the falling edge.
//  Config      : follows IMEM_LOADER_CHECKSUM_EN for frame format.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   byte_count;
    logic              cpu_hold;

    int n_pass  = 0;
    int n_total = 0;

    // Write-side observation log
    logic [7:0] tb_mem [0:MEM_BYTES-1];
    int wr_pulses  = 0;
    int cyc        = 0;
    int wr_cyc [0:7];
    int first_addr = 0;
    int last_addr  = 0;
    int max_addr   = 0;

    always #5 clk = ~clk;

    imem_loader #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count),
        .cpu_hold   (cpu_hold)
    );

    // Cycle counter for write-spacing checks
    always @(posedge clk) cyc = cyc + 1;

    // Record every memory write seen on the write port
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            tb_mem[wr_addr] = wr_data;
            if (wr_pulses < 8) wr_cyc[wr_pulses] = cyc;
            if (wr_pulses == 0) first_addr = int'(wr_addr);
            last_addr = int'(wr_addr);
            if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
            wr_pulses = wr_pulses + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        wr_pulses = 0;
        max_addr  = 0;
        last_addr = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader accepts it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(posedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 20);
        if (in_ready !== 1'b1) begin
            n_total++;
            $error("FAIL accept_timeout: byte 0x%0h observed no in_ready required in_ready=1", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Same as send_byte but sometimes leaves an idle cycle first
    task automatic send_byte_gap(input logic [7:0] b);
        if ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        send_byte(b);
    endtask

    // Directed test sequence
    initial begin
        logic [7:0] acc;
        logic [7:0] b;
        int         bad;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_wr_en",      32'(wr_en),      32'd0);
        check("rst_wr_addr",    32'(wr_addr),    32'd0);
        check("rst_wr_data",    32'(wr_data),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // ---------------- good 3-byte frame ----------------
        clear_log();
        pulse_start();
        check("start_busy",     32'(busy),     32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'hF2);
        send_byte(8'h0A);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hC8);
        check("f1_wr_en_at_done", 32'(wr_en), 32'd0);
`else
        check("f1_wr_en_at_done", 32'(wr_en), 32'd1);
`endif
        check("f1_done",       32'(done),       32'd1);
        check("f1_error",      32'(error),      32'd0);
        check("f1_cpu_hold",   32'(cpu_hold),   32'd0);
        check("f1_busy",       32'(busy),       32'd0);
        check("f1_byte_count", 32'(byte_count), 32'd3);
        @(negedge clk);
        check("f1_wr_pulses", 32'(wr_pulses), 32'd3);
        check("f1_mem0",      32'(tb_mem[0]), 32'h30);
        check("f1_mem1",      32'(tb_mem[1]), 32'hF2);
        check("f1_mem2",      32'(tb_mem[2]), 32'h0A);
        check("f1_spacing01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
        check("f1_spacing12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---------------- bad checksum ----------------
        tb_mem[0] = 8'h00;
        tb_mem[1] = 8'h00;
        tb_mem[2] = 8'h00;
        clear_log();
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h30);
        send_byte(8'hF2);
        send_byte(8'h0A);
        send_byte(8'h00);
        check("f2_error",    32'(error),    32'd1);
        check("f2_done",     32'(done),     32'd0);
        check("f2_cpu_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check("f2_wr_pulses", 32'(wr_pulses), 32'd3);
        check("f2_mem2",      32'(tb_mem[2]), 32'h0A);
`endif

        // ---------------- oversize length 1025 ----------------
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        check("ovr_error",    32'(error),    32'd1);
        check("ovr_done",     32'(done),     32'd0);
        check("ovr_cpu_hold", 32'(cpu_hold), 32'd1);
        check("ovr_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("ovr_wr_pulses", 32'(wr_pulses), 32'd0);

        // ---------------- zero-length frame ----------------
        clear_log();
        pulse_start();
        check("zl_error_cleared", 32'(error), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check("zl_done",       32'(done),       32'd1);
        check("zl_byte_count", 32'(byte_count), 32'd0);
        @(negedge clk);
        check("zl_wr_pulses", 32'(wr_pulses), 32'd0);

        // ---------------- full 1024-byte frame with gaps ----------------
        clear_log();
        pulse_start();
        send_byte_gap(8'h00);
        send_byte_gap(8'h04);
        acc = 8'h00;
        for (int i = 0; i < MEM_BYTES; i++) begin
            b   = 8'((i * 7 + 3) & 32'hFF);
            acc = acc ^ b;
            send_byte_gap(b);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte_gap(acc);
`endif
        check("full_done",       32'(done),       32'd1);
        check("full_byte_count", 32'(byte_count), 32'd1024);
        @(negedge clk);
        check("full_wr_pulses", 32'(wr_pulses), 32'd1024);
        check("full_last_addr", 32'(last_addr), 32'h3FF);
        check("full_max_addr",  32'(max_addr),  32'h3FF);
        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            b = 8'((i * 7 + 3) & 32'hFF);
            if (tb_mem[i] !== b) bad++;
        end
        check("full_mem_bad_bytes", 32'(bad), 32'd0);

        // ---------------- reset mid-load, then reload ----------------
        clear_log();
        pulse_start();
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",       32'(busy),       32'd0);
        check("mid_rst_in_ready",   32'(in_ready),   32'd0);
        check("mid_rst_wr_en",      32'(wr_en),      32'd0);
        check("mid_rst_wr_addr",    32'(wr_addr),    32'd0);
        check("mid_rst_byte_count", 32'(byte_count), 32'd0);
        check("mid_rst_cpu_hold",   32'(cpu_hold),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h11);
`endif
        check("reload_done", 32'(done), 32'd1);
        @(negedge clk);
        check("reload_first_addr", 32'(first_addr), 32'd0);
        check("reload_mem0",       32'(tb_mem[0]),  32'hAA);
        check("reload_mem1",       32'(tb_mem[1]),  32'hBB);

        // ---------------- start while busy, valid while DONE ----------------
        clear_log();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_start();
        check("busy_start_busy",       32'(busy),       32'd1);
        check("busy_start_in_ready",   32'(in_ready),   32'd1);
        check("busy_start_byte_count", 32'(byte_count), 32'd2);
        send_byte(8'h03);
        send_byte(8'h04);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h04);
`endif
        check("busy_start_done",  32'(done),       32'd1);
        check("busy_start_count", 32'(byte_count), 32'd4);
        @(negedge clk);
        check("busy_start_mem2", 32'(tb_mem[2]), 32'h03);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("done_valid_in_ready",   32'(in_ready),   32'd0);
        check("done_valid_done",       32'(done),       32'd1);
        check("done_valid_cpu_hold",   32'(cpu_hold),   32'd0);
        check("done_valid_byte_count", 32'(byte_count), 32'd4);
        check("done_valid_wr_pulses",  32'(wr_pulses),  32'd4);
        in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
